roteador_rr: RTL

- Parametrised N-channel, W-bit router; next generation of the team's 4:1 combinational roteador.
- Adds registered output, valid/ready handshake per channel, and two modes:
  - FIXED: the channel is chosen by sel.
  - ROUND_ROBIN: fair rotation among requesting channels.
- Sits between several producer blocks and a single shared consumer (bus, display driver, FIFO).

---
 rtl/roteador_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/roteador_rr.sv | 105 ++++++++++
 3 files changed

// File: rtl/roteador_pkg.sv
// Shared types and defaults for the roteador router family.
//   mode_t   : routing mode. FIXED routes the channel named by sel,
//              ROUND_ROBIN rotates fairly among requesting channels.
//   DEF_N/W  : default channel count and data width.
package roteador_pkg;

  typedef enum logic {
    FIXED       = 1'b0,
    ROUND_ROBIN = 1'b1
  } mode_t;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req         : N request bits, one per channel.
//   ptr         : last granted channel; the scan starts at ptr+1.
//   grant       : index of the first requester at or after ptr+1 (mod N).
//   grant_valid : high when some request is present.
module rr_arbiter #(
  parameter  int N        = roteador_pkg::DEF_N,
  localparam int SEL_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [SEL_BITS-1:0] ptr,
  output logic [SEL_BITS-1:0] grant,
  output logic                grant_valid
);

  int idx;

  // Scan ptr+1, ptr+2, ... wrapping at N-1 -> 0; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = SEL_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/roteador_rr.sv
// N-channel, W-bit router with a registered output and valid/ready handshakes.
//
// Handshake: a word moves across an interface on a rising edge when both
// valid and ready are high on that interface. in_ready is one-hot or zero and
// is computed combinationally from in_valid, mode/sel, the round-robin pointer
// and the state of the output register (it never depends on in_ready itself).
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset.
//   mode         : FIXED (route channel sel) or ROUND_ROBIN.
//   sel          : channel routed in FIXED mode; sel >= N grants nothing.
//   in_valid     : per-channel request.
//   in_data      : channel i data at [i*W +: W].
//   in_ready     : per-channel accept strobe.
//   out_valid    : output register holds a word.
//   out_data     : routed word.
//   out_chan     : source channel of out_data.
//   out_ready    : consumer takes the word this cycle.
module roteador_rr
  import roteador_pkg::*;
#(
  parameter  int N        = DEF_N,
  parameter  int W        = DEF_W,
  localparam int SEL_BITS = $clog2(N)
) (
  input  logic                clock,
  input  logic                reset,
  input  mode_t               mode,
  input  logic [SEL_BITS-1:0] sel,
  input  logic [N-1:0]        in_valid,
  input  logic [N*W-1:0]      in_data,
  output logic [N-1:0]        in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_BITS-1:0] out_chan,
  input  logic                out_ready
);

  logic [SEL_BITS-1:0] ptr;
  logic [SEL_BITS-1:0] rr_grant;
  logic                rr_valid;
  logic                fixed_valid;
  logic [SEL_BITS-1:0] grant;
  logic                grant_valid;
  logic [W-1:0]        grant_data;
  logic                can_load;

  rr_arbiter #(.N(N)) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Register is free when empty or being drained this cycle.
  assign can_load = !out_valid || out_ready;

  // Compare sel against each legal index so an out-of-range sel matches none.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel) == i) fixed_valid = in_valid[i];
    end
  end

  always_comb begin
    grant       = sel;
    grant_valid = fixed_valid;
    if (mode == ROUND_ROBIN) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(grant) == i) begin
        grant_data  = in_data[i*W +: W];
        in_ready[i] = grant_valid && can_load && !reset;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_BITS'(N - 1);  // channel 0 is scanned first
    end else if (can_load) begin
      if (grant_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant;
        if (mode == ROUND_ROBIN) ptr <= grant;
      end else begin
        // Drained with nothing to refill; data/chan keep their last value.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
